// File: rtl/sparse_chunk_sram_if.sv
// -----------------------------------------------------------------------------
// sparse_chunk_sram_if
//   Bundles the write, read, release and status signals of sparse_chunk_sram.
//   The clock and reset are not part of this bundle and stay plain ports.
//
//   Write side : wr_valid_i, wr_sparsemap_i, wr_nonzero_data_i,
//                wr_dat_count_i (beat index), wr_chunk_count_i (slot)
//   Read side  : rd_req_i, rd_chunk_i, rd_dat_count_i -> rd_valid_o,
//                rd_miss_o, rd_sparsemap_o, rd_nonzero_data_o, chunk_nz_cnt_o
//   Release    : release_i, release_chunk_i
//   Status     : chunk_valid_o (per slot), wr_err_o (sticky)
//
//   Modports: slave is the memory side, master is the producer/consumer side.
// -----------------------------------------------------------------------------
interface sparse_chunk_sram_if #(
  parameter int BUS_SIZE       = 32,
  parameter int WR_DAT_CYC_NUM = 4,
  parameter int CHUNK_NUM      = 4
);
  localparam int DW = $clog2(WR_DAT_CYC_NUM);
  localparam int CW = $clog2(CHUNK_NUM);
  localparam int NW = $clog2(BUS_SIZE * WR_DAT_CYC_NUM + 1);

  logic                  wr_valid_i;
  logic [BUS_SIZE-1:0]   wr_sparsemap_i;
  logic [BUS_SIZE*8-1:0] wr_nonzero_data_i;
  logic [DW-1:0]         wr_dat_count_i;
  logic [CW-1:0]         wr_chunk_count_i;

  logic                  rd_req_i;
  logic [CW-1:0]         rd_chunk_i;
  logic [DW-1:0]         rd_dat_count_i;
  logic                  rd_valid_o;
  logic                  rd_miss_o;
  logic [BUS_SIZE-1:0]   rd_sparsemap_o;
  logic [BUS_SIZE*8-1:0] rd_nonzero_data_o;
  logic [NW-1:0]         chunk_nz_cnt_o;

  logic                  release_i;
  logic [CW-1:0]         release_chunk_i;

  logic [CHUNK_NUM-1:0]  chunk_valid_o;
  logic                  wr_err_o;

  modport slave (
    input  wr_valid_i, wr_sparsemap_i, wr_nonzero_data_i, wr_dat_count_i,
           wr_chunk_count_i, rd_req_i, rd_chunk_i, rd_dat_count_i,
           release_i, release_chunk_i,
    output rd_valid_o, rd_miss_o, rd_sparsemap_o, rd_nonzero_data_o,
           chunk_nz_cnt_o, chunk_valid_o, wr_err_o
  );

  modport master (
    output wr_valid_i, wr_sparsemap_i, wr_nonzero_data_i, wr_dat_count_i,
           wr_chunk_count_i, rd_req_i, rd_chunk_i, rd_dat_count_i,
           release_i, release_chunk_i,
    input  rd_valid_o, rd_miss_o, rd_sparsemap_o, rd_nonzero_data_o,
           chunk_nz_cnt_o, chunk_valid_o, wr_err_o
  );
endinterface

// File: rtl/sparse_chunk_sram.sv
// -----------------------------------------------------------------------------
// sparse_chunk_sram
//   Chunked storage for sparse-encoded data. A producer streams a chunk of
//   WR_DAT_CYC_NUM beats (index 0..N-1, in order, gaps allowed) into one of
//   CHUNK_NUM slots. Once the last beat lands the slot is marked valid together
//   with the chunk's total nonzero count (popcount of all sparsemaps). A
//   consumer reads single beats of valid slots and frees slots with release.
//   Any out-of-order or colliding write beat is dropped, abandons the chunk in
//   progress and sets the sticky wr_err flag.
//
// Ports
//   clk_i  : clock, all state on the rising edge
//   rst_i  : asynchronous active-low reset
//   bus    : sparse_chunk_sram_if.slave (write / read / release / status)
// -----------------------------------------------------------------------------
module sparse_chunk_sram #(
  parameter int BUS_SIZE       = 32,
  parameter int WR_DAT_CYC_NUM = 4,
  parameter int CHUNK_NUM      = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  sparse_chunk_sram_if.slave    bus
);
  localparam int DW    = $clog2(WR_DAT_CYC_NUM);
  localparam int CW    = $clog2(CHUNK_NUM);
  localparam int NW    = $clog2(BUS_SIZE * WR_DAT_CYC_NUM + 1);
  localparam int DATW  = BUS_SIZE * 8;
  localparam int BEATS = CHUNK_NUM * WR_DAT_CYC_NUM;
  localparam int AW    = CW + DW;

  localparam logic [DW-1:0] LAST_BEAT = DW'(WR_DAT_CYC_NUM - 1);

  typedef enum logic {IDLE, FILL} state_e;

  state_e               state_q, state_d;
  logic [DW-1:0]        exp_cnt_q, exp_cnt_d;
  logic [CW-1:0]        cur_chunk_q, cur_chunk_d;
  logic [NW-1:0]        nz_acc_q, nz_acc_d;
  logic                 wr_err_q, wr_err_d;
  logic [CHUNK_NUM-1:0] chunk_valid_q, chunk_valid_d;
  logic [NW-1:0]        nz_cnt_q [CHUNK_NUM];
  logic [NW-1:0]        nz_cnt_d [CHUNK_NUM];

  logic                 rd_valid_q, rd_miss_q;
  logic [BUS_SIZE-1:0]  rd_smap_q;
  logic [DATW-1:0]      rd_data_q;
  logic [NW-1:0]        rd_nz_q;

  logic [BUS_SIZE-1:0]  mem_smap [BEATS];
  logic [DATW-1:0]      mem_data [BEATS];

  logic [NW-1:0]        beat_pop;
  logic [NW-1:0]        nz_sum;
  logic                 accept;
  logic                 complete;
  logic                 rd_hit;
  logic [AW-1:0]        wr_addr;
  logic [AW-1:0]        rd_addr;

  // Only the sparsemap is counted; the packed data bytes are never inspected.
  // NOTE: combinational blocks use blocking '=' so the accumulation reads the
  // value just computed; sequential blocks below use '<=' exclusively.
  always_comb begin
    beat_pop = '0;
    for (int i = 0; i < BUS_SIZE; i++) begin
      beat_pop = beat_pop + NW'(bus.wr_sparsemap_i[i]);
    end
  end

  assign nz_sum  = nz_acc_q + beat_pop;
  assign wr_addr = {bus.wr_chunk_count_i, bus.wr_dat_count_i};
  assign rd_addr = {bus.rd_chunk_i, bus.rd_dat_count_i};

  // Write FSM: decides whether the incoming beat is accepted.
  // NOTE: every signal gets a default before the case so no path leaves a
  // variable unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d     = state_q;
    exp_cnt_d   = exp_cnt_q;
    cur_chunk_d = cur_chunk_q;
    nz_acc_d    = nz_acc_q;
    wr_err_d    = wr_err_q;
    accept      = 1'b0;
    complete    = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.wr_valid_i) begin
          // A chunk may only start at beat 0 into a free slot.
          if (bus.wr_dat_count_i == '0 && !chunk_valid_q[bus.wr_chunk_count_i]) begin
            accept      = 1'b1;
            nz_acc_d    = beat_pop;
            exp_cnt_d   = DW'(1);
            cur_chunk_d = bus.wr_chunk_count_i;
            state_d     = FILL;
          end else begin
            wr_err_d = 1'b1;
          end
        end
      end
      FILL: begin
        if (bus.wr_valid_i) begin
          if (bus.wr_dat_count_i == exp_cnt_q && bus.wr_chunk_count_i == cur_chunk_q) begin
            accept    = 1'b1;
            nz_acc_d  = nz_sum;
            exp_cnt_d = exp_cnt_q + DW'(1);
            if (bus.wr_dat_count_i == LAST_BEAT) begin
              complete = 1'b1;
              state_d  = IDLE;
            end
          end else begin
            // Protocol break: the partial chunk is abandoned and its slot
            // stays invalid. The offending beat is not retried from IDLE.
            wr_err_d = 1'b1;
            state_d  = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Slot flags. Release is applied first so a completion on the same slot in
  // the same cycle overrides it and leaves the slot valid.
  always_comb begin
    chunk_valid_d = chunk_valid_q;
    nz_cnt_d      = nz_cnt_q;
    if (bus.release_i) begin
      chunk_valid_d[bus.release_chunk_i] = 1'b0;
    end
    if (complete) begin
      chunk_valid_d[cur_chunk_q] = 1'b1;
      nz_cnt_d[cur_chunk_q]      = nz_sum;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q       <= IDLE;
      exp_cnt_q     <= '0;
      cur_chunk_q   <= '0;
      nz_acc_q      <= '0;
      wr_err_q      <= 1'b0;
      chunk_valid_q <= '0;
      nz_cnt_q      <= '{default: '0};
    end else begin
      state_q       <= state_d;
      exp_cnt_q     <= exp_cnt_d;
      cur_chunk_q   <= cur_chunk_d;
      nz_acc_q      <= nz_acc_d;
      wr_err_q      <= wr_err_d;
      chunk_valid_q <= chunk_valid_d;
      nz_cnt_q      <= nz_cnt_d;
    end
  end

  // NOTE: the storage array has no reset; a slot's contents are only readable
  // once its valid flag is set, which requires a complete rewrite after reset.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      mem_smap[wr_addr] <= bus.wr_sparsemap_i;
      mem_data[wr_addr] <= bus.wr_nonzero_data_i;
    end
  end

  // Read port: valid check uses the flags before this edge's release or
  // completion, so a slot still being filled misses and a slot released in
  // the same cycle still answers. Data outputs hold across misses.
  assign rd_hit = bus.rd_req_i && chunk_valid_q[bus.rd_chunk_i];

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rd_valid_q <= 1'b0;
      rd_miss_q  <= 1'b0;
      rd_smap_q  <= '0;
      rd_data_q  <= '0;
      rd_nz_q    <= '0;
    end else begin
      rd_valid_q <= rd_hit;
      rd_miss_q  <= bus.rd_req_i && !chunk_valid_q[bus.rd_chunk_i];
      if (rd_hit) begin
        rd_smap_q <= mem_smap[rd_addr];
        rd_data_q <= mem_data[rd_addr];
        rd_nz_q   <= nz_cnt_q[bus.rd_chunk_i];
      end
    end
  end

  assign bus.rd_valid_o        = rd_valid_q;
  assign bus.rd_miss_o         = rd_miss_q;
  assign bus.rd_sparsemap_o    = rd_smap_q;
  assign bus.rd_nonzero_data_o = rd_data_q;
  assign bus.chunk_nz_cnt_o    = rd_nz_q;
  assign bus.chunk_valid_o     = chunk_valid_q;
  assign bus.wr_err_o          = wr_err_q;

endmodule

// File: doc/sparse_chunk_sram.md
SPARSE_CHUNK_SRAM -- requirements
Module: sparse_chunk_sram

Interface
REQ-001 SHALL have parameter BUS_SIZE, default 32, sparsemap bits per beat; data bus is BUS_SIZE*8 bits.
REQ-002 SHALL have parameter WR_DAT_CYC_NUM, default 4, beats per chunk (power of 2, >=2).
REQ-003 SHALL have parameter CHUNK_NUM, default 4, chunk slots (power of 2, >=2).
REQ-004 SHALL use derived widths DW=$clog2(WR_DAT_CYC_NUM), CW=$clog2(CHUNK_NUM), NW=$clog2(BUS_SIZE*WR_DAT_CYC_NUM+1).
REQ-005 clk_i  in  1  single clock, all state on rising edge.
REQ-006 rst_i  in  1  reset, asynchronous, active-low.
REQ-007 wr_valid_i  in  1  write beat valid; no backpressure.
REQ-008 wr_sparsemap_i  in  BUS_SIZE  beat sparsemap.
REQ-009 wr_nonzero_data_i  in  BUS_SIZE*8  beat packed nonzero bytes.
REQ-010 wr_dat_count_i  in  DW  beat index within chunk.
REQ-011 wr_chunk_count_i  in  CW  target chunk slot.
REQ-012 rd_req_i / rd_chunk_i / rd_dat_count_i  in  1 / CW / DW  read request, slot, beat.
REQ-013 rd_valid_o / rd_sparsemap_o / rd_nonzero_data_o  out  1 / BUS_SIZE / BUS_SIZE*8  read response.
REQ-014 rd_miss_o  out  1  pulse: read of non-valid slot.
REQ-015 release_i / release_chunk_i  in  1 / CW  consumer frees a slot.
REQ-016 chunk_valid_o  out  CHUNK_NUM  per-slot complete-and-unreleased flag.
REQ-017 chunk_nz_cnt_o  out  NW  nonzero count of slot rd_chunk_i, registered with read response.
REQ-018 wr_err_o  out  1  sticky protocol-error flag.

Function
REQ-019 Write FSM SHALL have states IDLE and FILL, with registers exp_cnt (DW), cur_chunk (CW), nz_acc (NW).
REQ-020 IDLE + wr_valid_i + wr_dat_count_i==0 + slot not valid -> store beat, nz_acc=popcount(sparsemap), exp_cnt=1, latch chunk, go FILL.
REQ-021 IDLE + wr_valid_i with dat_count!=0 or target slot valid -> drop beat, set wr_err_o, stay IDLE.
REQ-022 FILL + wr_valid_i + dat_count==exp_cnt + chunk==cur_chunk -> store beat, nz_acc+=popcount, exp_cnt+=1.
REQ-023 Accepted beat with dat_count==WR_DAT_CYC_NUM-1 SHALL set chunk_valid_o[cur_chunk] and nz_cnt[cur_chunk]=final nz_acc on the next edge, go IDLE.
REQ-024 FILL + wr_valid_i with mismatched count or chunk -> drop beat, set wr_err_o, abandon chunk (slot stays invalid), go IDLE; same beat is not re-evaluated.
REQ-025 FILL with wr_valid_i low SHALL hold state (gaps allowed).
REQ-026 Popcount SHALL count ones in wr_sparsemap_i only; data bytes not inspected.
REQ-027 Read: rd_req_i at edge N with slot valid -> rd_valid_o=1 at N+1 with stored beat and nz count; invalid slot -> rd_miss_o=1 at N+1, rd_valid_o=0, data outputs hold.
REQ-028 rd_valid_o and rd_miss_o SHALL be single-cycle pulses per request; back-to-back requests give back-to-back responses.
REQ-029 release_i SHALL clear chunk_valid_o[release_chunk_i] next edge; release of invalid slot is a no-op.
REQ-030 Completion and release on same slot same cycle: completion wins (slot valid).
REQ-031 Read and release of same slot same cycle: read uses pre-release state (responds valid).
REQ-032 Read of slot being filled SHALL miss; storage writes bypass nothing.

Reset
REQ-033 rst_i low SHALL immediately force IDLE, exp_cnt=0, nz_acc=0, chunk_valid_o=0, nz_cnt=0, rd_valid_o=0, rd_miss_o=0, wr_err_o=0, rd data outputs=0, chunk_nz_cnt_o=0.
REQ-034 Storage array contents SHALL NOT require reset; unreadable until slot rewritten.
REQ-035 Reset mid-FILL SHALL discard the partial chunk; first post-reset beat must be dat_count 0.

Verification
REQ-036 Write slot 2, beats 0-3, sparsemaps 0xFFFF0000 each -> chunk_valid_o=4'b0100; read slot 2 beat 1 -> next cycle rd_valid_o=1, sparsemap 0xFFFF0000, chunk_nz_cnt_o=64.
REQ-037 Slot 1 beats 0,1,3 -> wr_err_o=1 at beat 3, chunk_valid_o[1]=0; read slot 1 -> rd_miss_o=1.
REQ-038 Fill slots 0-3 back-to-back, no gaps -> chunk_valid_o=4'hF after 16 beats; rewrite slot 0 -> wr_err_o=1, beat dropped.
REQ-039 Release slot 3 same cycle as read slot 3 -> rd_valid_o=1 next cycle, chunk_valid_o[3]=0 after.
REQ-040 Assert rst_i low after beat 2 of slot 0 -> all outputs 0; restart slot 0 beats 0-3 -> chunk_valid_o[0]=1, nz count matches new sparsemaps only.
